// File: rtl/fifo_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_serial_tx_pkg
// Description : Shared constants, FSM state encoding and frame-length helper
//               for the FIFO-fed serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_serial_tx_pkg;

    // Default byte width; must match the width of the feeding FIFO.
    localparam int DATA_W_DEF = 8;

    // Transmitter FSM states, 3-bit binary encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_DATA    = 3'd4,
        ST_STOP    = 3'd5
    } tx_state_e;

    // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                        input int stop_bits);
        return (1 + data_w + stop_bits) * clks_per_bit;
    endfunction

    localparam int FRAME_CYCLES_DEF = frame_cycles(DATA_W_DEF, 16, 1);

endpackage
`default_nettype wire

// File: rtl/fifo_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : fifo_serial_tx_if
// Description : Read port of a byte FIFO (empty flag, pop strobe, read data).
//               The transmitter uses the master view, the FIFO the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_serial_tx_if
    import fifo_serial_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dataout;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dataout
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dataout
    );
endinterface
`default_nettype wire

// File: rtl/fifo_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_tx_bit_timer
// Description : Bit-period divider. tick marks the last cycle of each bit
//               period; pre_tick marks the cycle before it.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    output logic      tick,
    output logic      pre_tick
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] clk_cnt;

    // Free-running cycle counter that wraps at the end of each bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
        end else if (clear || tick) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    assign tick     = (clk_cnt == LAST);
    assign pre_tick = (clk_cnt == PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_tx
// Description : Pops bytes from a FIFO and sends each as a serial frame:
//               start bit (0), DATA_W bits LSB first, STOP_BITS stop bits (1).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               tx_en,
    fifo_serial_tx_if.master        fifo,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int            BW        = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              tx_nxt;
    logic              done_nxt;
    logic              timer_clear;
    logic              tick;
    logic              pre_tick;

    fifo_serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // Next-state, counter, shift-register and output-register decode.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;

        unique case (state)
            ST_IDLE: begin
                if (tx_en && !fifo.fifo_empty) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // FIFO read data is valid now, one cycle after the pop strobe.
                shift_nxt = fifo.fifo_dataout;
                state_nxt = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        shift_nxt   = shift_reg >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_nxt = (tx_en && !fifo.fifo_empty) ? ST_POP : ST_IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Both counters restart on every state change.
        if (state_nxt != state) begin
            bit_cnt_nxt = '0;
        end
        timer_clear = (state_nxt != state) || (state == ST_IDLE);

        // Line level for the coming cycle, so tx_out itself is a flop.
        unique case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase

        // Raise frame_done for the final cycle of the last stop bit.
        done_nxt = (state == ST_STOP) && (bit_cnt == LAST_STOP) && pre_tick;
    end

    // State, datapath and registered outputs; reset drops the frame at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            tx_out     <= tx_nxt;
            frame_done <= done_nxt;
        end
    end

    assign fifo.fifo_rd_en = (state == ST_POP);
    assign busy            = (state != ST_IDLE);

endmodule
`default_nettype wire
